// File: rtl/tc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tc_pkg
//  Description : Types and constants shared by the GEMM tile scheduler and the
//                tensor core control unit. command_t is the 64-bit tile
//                command exchanged over the command port (LSB first:
//                len_m, len_k, len_n, addr_a, addr_b, addr_c, addr_d).
//  Revision    : 1.0 - initial release
// ============================================================================
package tc_pkg;

    // Systolic array tile edge (rows/cols per tile).
    localparam int W = 16;

    // Scratchpad row address width carried by a command.
    localparam int TC_ADDR_W = 10;

    typedef struct packed {
        logic [TC_ADDR_W-1:0] addr_d;
        logic [TC_ADDR_W-1:0] addr_c;
        logic [TC_ADDR_W-1:0] addr_b;
        logic [TC_ADDR_W-1:0] addr_a;
        logic [7:0]           len_n;
        logic [7:0]           len_k;
        logic [7:0]           len_m;
    } command_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/gemm_tile_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : gemm_tile_scheduler_if
//  Description : Command port between the tile scheduler (master) and the
//                tensor core control unit (slave).
//                  cmd_valid / cmd_data / cmd_ready : tile command handshake
//                  done_irq                         : one pulse per finished tile
//  Revision    : 1.0 - initial release
// ============================================================================
interface gemm_tile_scheduler_if;
    import tc_pkg::*;

    logic     cmd_valid;
    command_t cmd_data;
    logic     cmd_ready;
    logic     done_irq;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready,
        input  done_irq
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready,
        output done_irq
    );

endinterface
`default_nettype wire

// File: rtl/tile_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tile_addr_gen
//  Description : Walks the (mt, nt) tile grid of one job in row-major order
//                (nt inner) and produces the command for the current tile.
//                Addresses advance with registered adders only and wrap
//                modulo 2^ADDR_WIDTH.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_load            - latch descriptor, point at tile (0,0)
//                i_step            - advance to the next tile
//                i_tiles_m/n, i_last_m/n, i_len_k, i_base_a..d - descriptor
//                o_cmd             - command for the current tile
//                o_is_last         - current tile is the final one of the job
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_addr_gen
    import tc_pkg::*;
#(
    parameter int ADDR_WIDTH           = TC_ADDR_W,
    parameter int SYSTOLIC_ARRAY_WIDTH = W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [7:0]            i_tiles_m,
    input  logic [7:0]            i_tiles_n,
    input  logic [4:0]            i_last_m,
    input  logic [4:0]            i_last_n,
    input  logic [7:0]            i_len_k,
    input  logic [ADDR_WIDTH-1:0] i_base_a,
    input  logic [ADDR_WIDTH-1:0] i_base_b,
    input  logic [ADDR_WIDTH-1:0] i_base_c,
    input  logic [ADDR_WIDTH-1:0] i_base_d,
    output command_t              o_cmd,
    output logic                  o_is_last
);

    localparam logic [ADDR_WIDTH-1:0] c_STEP = ADDR_WIDTH'(SYSTOLIC_ARRAY_WIDTH);
    localparam logic [7:0]            c_W8   = 8'(SYSTOLIC_ARRAY_WIDTH);

    logic [7:0]            r_tiles_m;
    logic [7:0]            r_tiles_n;
    logic [4:0]            r_last_m;
    logic [4:0]            r_last_n;
    logic [7:0]            r_len_k;
    logic [ADDR_WIDTH-1:0] r_base_b;
    logic [7:0]            r_mt;
    logic [7:0]            r_nt;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [ADDR_WIDTH-1:0] r_addr_c;
    logic [ADDR_WIDTH-1:0] r_addr_d;

    logic w_last_row;
    logic w_last_col;

    assign w_last_row = (r_mt == r_tiles_m - 8'd1);
    assign w_last_col = (r_nt == r_tiles_n - 8'd1);
    assign o_is_last  = w_last_row && w_last_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tiles_m <= '0;
            r_tiles_n <= '0;
            r_last_m  <= '0;
            r_last_n  <= '0;
            r_len_k   <= '0;
            r_base_b  <= '0;
            r_mt      <= '0;
            r_nt      <= '0;
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_addr_c  <= '0;
            r_addr_d  <= '0;
        end else if (i_load) begin
            r_tiles_m <= i_tiles_m;
            r_tiles_n <= i_tiles_n;
            r_last_m  <= i_last_m;
            r_last_n  <= i_last_n;
            r_len_k   <= i_len_k;
            r_base_b  <= i_base_b;
            r_mt      <= '0;
            r_nt      <= '0;
            r_addr_a  <= i_base_a;
            r_addr_b  <= i_base_b;
            r_addr_c  <= i_base_c;
            r_addr_d  <= i_base_d;
        end else if (i_step) begin
            // C and D are indexed by the linear tile number, so they advance
            // on every tile regardless of row/column position.
            r_addr_c <= r_addr_c + c_STEP;
            r_addr_d <= r_addr_d + c_STEP;
            if (w_last_col) begin
                r_nt     <= '0;
                r_mt     <= r_mt + 8'd1;
                r_addr_a <= r_addr_a + c_STEP;
                r_addr_b <= r_base_b;
            end else begin
                r_nt     <= r_nt + 8'd1;
                r_addr_b <= r_addr_b + c_STEP;
            end
        end
    end

    always_comb begin
        o_cmd        = '0;
        o_cmd.addr_a = r_addr_a;
        o_cmd.addr_b = r_addr_b;
        o_cmd.addr_c = r_addr_c;
        o_cmd.addr_d = r_addr_d;
        o_cmd.len_k  = r_len_k;
        o_cmd.len_m  = w_last_row ? {3'b000, r_last_m} : c_W8;
        o_cmd.len_n  = w_last_col ? {3'b000, r_last_n} : c_W8;
    end

endmodule
`default_nettype wire

// File: rtl/gemm_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : gemm_tile_scheduler
//  Description : Splits one GEMM job descriptor into row-major W x W tile
//                commands, pushes them to the control unit command port and
//                limits in-flight tiles using the done_irq completion pulses.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                i_job_*             - job descriptor with valid/ready
//                o_job_busy/o_job_done - status, one-cycle completion pulse
//                o_tiles_issued      - commands accepted in the current job
//                o_err_spurious      - sticky: done_irq with nothing in flight
//                cmd_if (master)     - cmd_valid/cmd_data/cmd_ready, done_irq
//  Revision    : 1.0 - initial release
// ============================================================================
module gemm_tile_scheduler
    import tc_pkg::*;
#(
    parameter int ADDR_WIDTH           = TC_ADDR_W,
    parameter int SYSTOLIC_ARRAY_WIDTH = W,
    parameter int MAX_OUTSTANDING      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_job_valid,
    output logic                  o_job_ready,
    input  logic [7:0]            i_job_tiles_m,
    input  logic [7:0]            i_job_tiles_n,
    input  logic [4:0]            i_job_last_m,
    input  logic [4:0]            i_job_last_n,
    input  logic [7:0]            i_job_len_k,
    input  logic [ADDR_WIDTH-1:0] i_job_base_a,
    input  logic [ADDR_WIDTH-1:0] i_job_base_b,
    input  logic [ADDR_WIDTH-1:0] i_job_base_c,
    input  logic [ADDR_WIDTH-1:0] i_job_base_d,
    gemm_tile_scheduler_if.master cmd_if,
    output logic                  o_job_busy,
    output logic                  o_job_done,
    output logic [15:0]           o_tiles_issued,
    output logic                  o_err_spurious
);

    localparam logic [3:0] c_MAX_OUT = 4'(MAX_OUTSTANDING);

    sched_state_t r_state;
    sched_state_t w_next_state;

    logic [3:0]  r_outstanding;
    logic [15:0] r_tiles_issued;
    logic        r_err_spurious;

    command_t    w_cmd;
    logic        w_is_last;
    logic        w_accept;
    logic        w_empty;
    logic        w_cmd_valid;
    logic        w_hs;
    logic        w_spurious;

    assign w_accept    = (r_state == ST_IDLE) && i_job_valid;
    assign w_empty     = (i_job_tiles_m == 8'd0) || (i_job_tiles_n == 8'd0);
    // Built only from registered state so it never depends on cmd_ready.
    assign w_cmd_valid = (r_state == ST_ISSUE) && (r_outstanding < c_MAX_OUT);
    assign w_hs        = w_cmd_valid && cmd_if.cmd_ready;
    // A completion coinciding with a handshake is balanced by it, so only a
    // lone done_irq against an empty counter is an error.
    assign w_spurious  = cmd_if.done_irq && !w_hs && (r_outstanding == 4'd0);

    tile_addr_gen #(
        .ADDR_WIDTH           (ADDR_WIDTH),
        .SYSTOLIC_ARRAY_WIDTH (SYSTOLIC_ARRAY_WIDTH)
    ) u_tile_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_step    (w_hs),
        .i_tiles_m (i_job_tiles_m),
        .i_tiles_n (i_job_tiles_n),
        .i_last_m  (i_job_last_m),
        .i_last_n  (i_job_last_n),
        .i_len_k   (i_job_len_k),
        .i_base_a  (i_job_base_a),
        .i_base_b  (i_job_base_b),
        .i_base_c  (i_job_base_c),
        .i_base_d  (i_job_base_d),
        .o_cmd     (w_cmd),
        .o_is_last (w_is_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_job_valid) w_next_state = w_empty ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (w_hs && w_is_last) w_next_state = ST_DRAIN;
            ST_DRAIN: if (r_outstanding == 4'd0) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_job_ready      = (r_state == ST_IDLE);
        o_job_busy       = (r_state != ST_IDLE);
        o_job_done       = (r_state == ST_DONE);
        cmd_if.cmd_valid = w_cmd_valid;
        // Bus reads zero whenever no command is offered.
        cmd_if.cmd_data  = w_cmd_valid ? w_cmd : '0;
        o_tiles_issued   = r_tiles_issued;
        o_err_spurious   = r_err_spurious;
    end

    // In-flight tile counter and job statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding  <= '0;
            r_tiles_issued <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            case ({w_hs, cmd_if.done_irq})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   if (r_outstanding != 4'd0) r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_accept) begin
                r_tiles_issued <= '0;
            end else if (w_hs) begin
                r_tiles_issued <= r_tiles_issued + 16'd1;
            end

            if (w_spurious) begin
                r_err_spurious <= 1'b1;
            end else if (w_accept) begin
                r_err_spurious <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gemm_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gemm_tile_scheduler
//  Description : Self-checking bench for gemm_tile_scheduler. Expected tile
//                commands come from a grid model written with plain
//                arithmetic; credit, stall and completion behaviour is tracked
//                with simple counters and a queue of pending completions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gemm_tile_scheduler;
    import tc_pkg::*;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [7:0]  tiles_m, tiles_n, len_k;
    logic [4:0]  last_m, last_n;
    logic [9:0]  base_a, base_b, base_c, base_d;
    logic        job_busy, job_done, err_spurious;
    logic [15:0] tiles_issued;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gemm_tile_scheduler_if u_if ();

    gemm_tile_scheduler #(
        .ADDR_WIDTH           (10),
        .SYSTOLIC_ARRAY_WIDTH (16),
        .MAX_OUTSTANDING      (MAXO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_job_valid    (job_valid),
        .o_job_ready    (job_ready),
        .i_job_tiles_m  (tiles_m),
        .i_job_tiles_n  (tiles_n),
        .i_job_last_m   (last_m),
        .i_job_last_n   (last_n),
        .i_job_len_k    (len_k),
        .i_job_base_a   (base_a),
        .i_job_base_b   (base_b),
        .i_job_base_c   (base_c),
        .i_job_base_d   (base_d),
        .cmd_if         (u_if.master),
        .o_job_busy     (job_busy),
        .o_job_done     (job_done),
        .o_tiles_issued (tiles_issued),
        .o_err_spurious (err_spurious)
    );

    typedef struct {
        int          tm, tn, lm, ln, k;
        int          ba, bb, bc, bd;
        int          ready_mode;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
        int          lat;          // done_irq latency, 0 = random
        int          exp_cnt;
        logic [63:0] exp_first;
        logic [63:0] exp_last;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_cmd(input vec_t v, input int mt, input int nt);
        int t, a, b, c, d, lm, ln;
        t  = mt * v.tn + nt;
        a  = (v.ba + mt * 16) % 1024;
        b  = (v.bb + nt * 16) % 1024;
        c  = (v.bc + t * 16) % 1024;
        d  = (v.bd + t * 16) % 1024;
        lm = (mt == v.tm - 1) ? v.lm : 16;
        ln = (nt == v.tn - 1) ? v.ln : 16;
        return {10'(d), 10'(c), 10'(b), 10'(a), 8'(ln), 8'(v.k), 8'(lm)};
    endfunction

    task automatic drive_desc(input vec_t v);
        tiles_m = 8'(v.tm);
        tiles_n = 8'(v.tn);
        last_m  = 5'(v.lm);
        last_n  = 5'(v.ln);
        len_k   = 8'(v.k);
        base_a  = 10'(v.ba);
        base_b  = 10'(v.bb);
        base_c  = 10'(v.bc);
        base_d  = 10'(v.bd);
    endtask

    // Accept a job and run it to completion, checking every cycle.
    task automatic run_job(input vec_t v, input string tag);
        logic [63:0] expq[$];
        int          due[$];
        int          issued = 0, outs = 0, cyc = 0, last_due = 0, lat;
        logic        pv = 1'b0, pr = 1'b0, rdy, dn, hs, exp_v;
        logic [63:0] pd = '0, first_d = '0, last_d = '0;
        bit          done_seen = 0;

        for (int mt = 0; mt < v.tm; mt++)
            for (int nt = 0; nt < v.tn; nt++)
                expq.push_back(model_cmd(v, mt, nt));

        @(negedge clk);
        chk({tag, " job_ready"}, 64'(job_ready), 64'd1);
        drive_desc(v);
        job_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        job_valid = 1'b0;
        chk({tag, " err_clear"}, 64'(err_spurious), 64'd0);

        while (!done_seen && cyc < 3000) begin
            if (job_done) begin
                done_seen = 1;
            end else begin
                if (pv && !pr) begin
                    chk({tag, " stall_valid"}, 64'(u_if.cmd_valid), 64'd1);
                    chk({tag, " stall_data"}, u_if.cmd_data, pd);
                end
                exp_v = (issued < expq.size()) && (outs < MAXO);
                chk({tag, " cmd_valid"}, 64'(u_if.cmd_valid), 64'(exp_v));

                case (v.ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                    default: rdy = ($urandom_range(0, 3) != 0);
                endcase
                u_if.cmd_ready = rdy;

                dn = 1'b0;
                if (due.size() > 0 && due[0] <= cyc) begin
                    dn = 1'b1;
                    void'(due.pop_front());
                end
                u_if.done_irq = dn;

                hs = u_if.cmd_valid && rdy;
                if (hs) begin
                    if (issued < expq.size())
                        chk($sformatf("%s cmd[%0d]", tag, issued), u_if.cmd_data, expq[issued]);
                    else
                        chk({tag, " extra_cmd"}, 64'd1, 64'd0);
                    if (issued == 0) first_d = u_if.cmd_data;
                    last_d = u_if.cmd_data;
                    issued++;
                    lat = (v.lat > 0) ? v.lat : int'($urandom_range(1, 8));
                    last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                    due.push_back(last_due);
                end
                pv = u_if.cmd_valid;
                pr = rdy;
                pd = u_if.cmd_data;

                @(posedge clk);
                outs = outs + int'(hs) - int'(dn);
                cyc++;
                @(negedge clk);
                u_if.done_irq = 1'b0;
            end
        end

        u_if.cmd_ready = 1'b0;
        chk({tag, " done_seen"}, 64'(done_seen), 64'd1);
        chk({tag, " issued"}, 64'(issued), 64'(v.exp_cnt));
        chk({tag, " outstanding"}, 64'(outs), 64'd0);
        chk({tag, " tiles_issued"}, 64'(tiles_issued), 64'(v.exp_cnt));
        chk({tag, " busy_at_done"}, 64'(job_busy), 64'd1);
        if (v.exp_cnt > 0) begin
            chk({tag, " first_cmd"}, first_d, v.exp_first);
            chk({tag, " last_cmd"}, last_d, v.exp_last);
        end
        @(negedge clk);
        chk({tag, " done_pulse"}, 64'(job_done), 64'd0);
        chk({tag, " ready_after"}, 64'(job_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " job_ready"}, 64'(job_ready), 64'd1);
        chk({tag, " job_busy"}, 64'(job_busy), 64'd0);
        chk({tag, " job_done"}, 64'(job_done), 64'd0);
        chk({tag, " cmd_valid"}, 64'(u_if.cmd_valid), 64'd0);
        chk({tag, " cmd_data"}, u_if.cmd_data, 64'd0);
        chk({tag, " tiles_issued"}, 64'(tiles_issued), 64'd0);
        chk({tag, " err_spurious"}, 64'(err_spurious), 64'd0);
    endtask

    // 2x3 job, always ready, no completions: credit limit, next-cycle credit
    // reuse and simultaneous handshake/completion.
    task automatic credit_test();
        vec_t v;
        int   hs_cnt = 0;
        v = '{2, 3, 16, 16, 4, 0, 0, 0, 0, 0, 1, 6, 64'd0, 64'd0};
        @(negedge clk);
        drive_desc(v);
        job_valid = 1'b1;
        u_if.cmd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        job_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (u_if.cmd_valid) hs_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("credit hs_count", 64'(hs_cnt), 64'd4);
        chk("credit valid_low", 64'(u_if.cmd_valid), 64'd0);
        u_if.done_irq = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("credit next_cycle_valid", 64'(u_if.cmd_valid), 64'd1);
        // Keep done_irq high: completion coincides with the handshake.
        @(posedge clk);
        @(negedge clk);
        u_if.done_irq = 1'b0;
        chk("simul valid_at_3", 64'(u_if.cmd_valid), 64'd1);
        chk("simul tiles_issued5", 64'(tiles_issued), 64'd5);
        @(posedge clk);
        @(negedge clk);
        chk("credit last_valid_low", 64'(u_if.cmd_valid), 64'd0);
        chk("credit tiles_issued6", 64'(tiles_issued), 64'd6);
        u_if.cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            u_if.done_irq = 1'b1;
            @(posedge clk);
            @(negedge clk);
            u_if.done_irq = 1'b0;
            chk($sformatf("drain no_done_%0d", i), 64'(job_done), 64'd0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("drain job_done", 64'(job_done), 64'd1);
        chk("drain err_clean", 64'(err_spurious), 64'd0);
        @(negedge clk);
        chk("drain ready_after", 64'(job_ready), 64'd1);
    endtask

    initial begin
        vec_t rv;
        rst = 1'b1;
        job_valid = 1'b0;
        u_if.cmd_ready = 1'b0;
        u_if.done_irq = 1'b0;
        drive_desc('{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0});

        tbl[0] = '{1, 1, 16, 16, 16, 'h000, 'h040, 'h080, 'h0C0, 0, 10, 1,
                   64'h3008_0100_0010_1010, 64'h3008_0100_0010_1010};
        tbl[1] = '{2, 3, 5, 9, 8, 'h010, 'h020, 'h3F8, 'h100, 0, 3, 6,
                   64'h403F_8080_1010_0810, 64'h5404_8100_2009_0805};
        tbl[2] = '{2, 3, 5, 9, 8, 'h010, 'h020, 'h3F8, 'h100, 1, 0, 6,
                   64'h403F_8080_1010_0810, 64'h5404_8100_2009_0805};
        tbl[3] = '{2, 0, 4, 4, 4, 'h011, 'h022, 'h033, 'h044, 0, 0, 0,
                   64'd0, 64'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 4; i++) run_job(tbl[i], $sformatf("vec%0d", i));

        // Spurious completion while idle, then a job proves no underflow.
        @(negedge clk);
        u_if.done_irq = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.done_irq = 1'b0;
        chk("spurious err_set", 64'(err_spurious), 64'd1);
        chk("spurious idle", 64'(job_ready), 64'd1);
        run_job(tbl[0], "after_spurious");

        // Empty job: completion pulse the cycle after acceptance.
        @(negedge clk);
        drive_desc(tbl[3]);
        job_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        job_valid = 1'b0;
        chk("empty job_done", 64'(job_done), 64'd1);
        chk("empty cmd_valid", 64'(u_if.cmd_valid), 64'd0);
        @(negedge clk);
        chk("empty done_once", 64'(job_done), 64'd0);
        chk("empty tiles_issued", 64'(tiles_issued), 64'd0);

        credit_test();

        // Reset while issuing.
        @(negedge clk);
        drive_desc(tbl[1]);
        job_valid = 1'b1;
        u_if.cmd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        job_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst busy", 64'(job_busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        u_if.cmd_ready = 1'b0;

        // Randomized jobs against the grid model.
        for (int j = 0; j < 10; j++) begin
            rv.tm = $urandom_range(0, 3);
            rv.tn = $urandom_range(0, 4);
            rv.lm = $urandom_range(1, 16);
            rv.ln = $urandom_range(1, 16);
            rv.k  = $urandom_range(1, 16);
            rv.ba = $urandom_range(0, 1023);
            rv.bb = $urandom_range(0, 1023);
            rv.bc = $urandom_range(0, 1023);
            rv.bd = $urandom_range(0, 1023);
            rv.ready_mode = 2;
            rv.lat = 0;
            rv.exp_cnt = rv.tm * rv.tn;
            rv.exp_first = model_cmd(rv, 0, 0);
            rv.exp_last  = model_cmd(rv, rv.tm - 1, rv.tn - 1);
            run_job(rv, $sformatf("rand%0d", j));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
